// File: rtl/pixel_compositor_if.sv
// Display-path bundle: object positions in, ROM address/data, composited video out.
interface pixel_compositor_if #(
  parameter int N_PIPES = 3
);
  logic [8:0]            bird_y;
  logic [10*N_PIPES-1:0] pipe_x;
  logic [9*N_PIPES-1:0]  pipe_y;
  logic [N_PIPES-1:0]    pipe_en;
  logic [11:0]           bird_rgb;
  logic [11:0]           land_rgb;
  logic [11:0]           bg_rgb;
  logic [9:0]            x_addr;
  logic [8:0]            y_addr;
  logic                  frame_start;
  logic                  collide;
  logic [3:0]            r;
  logic [3:0]            g;
  logic [3:0]            b;
  logic                  hs;
  logic                  vs;

  modport master (
    output bird_y, pipe_x, pipe_y, pipe_en, bird_rgb, land_rgb, bg_rgb,
    input  x_addr, y_addr, frame_start, collide, r, g, b, hs, vs
  );

  modport slave (
    input  bird_y, pipe_x, pipe_y, pipe_en, bird_rgb, land_rgb, bg_rgb,
    output x_addr, y_addr, frame_start, collide, r, g, b, hs, vs
  );
endinterface

// File: rtl/pixel_compositor.sv
// VGA timing plus layered bird/land/pipe/background compositor with
// frame-shadowed object positions, colour-key transparency and a
// per-frame bird collision flag. Two-stage pipeline behind the address.
module pixel_compositor #(
  parameter int          H_ACTIVE   = 640,
  parameter int          H_FP       = 16,
  parameter int          H_SYNC     = 96,
  parameter int          H_TOTAL    = 800,
  parameter int          V_ACTIVE   = 480,
  parameter int          V_FP       = 10,
  parameter int          V_SYNC     = 2,
  parameter int          V_TOTAL    = 525,
  parameter int          N_PIPES    = 3,
  parameter int          PIPE_W     = 100,
  parameter int          GAP_H      = 100,
  parameter int          LAND_H     = 100,
  parameter int          BIRD_X     = 320,
  parameter int          BIRD_W     = 34,
  parameter int          BIRD_H     = 24,
  parameter logic [11:0] KEY_COLOR  = 12'hFFF,
  parameter logic [11:0] PIPE_COLOR = 12'h0C0
) (
  input logic                vga_clk,
  input logic                clrn,
  pixel_compositor_if.slave  bus
);

  // Hit tests run in 12-bit signed space so edges near zero cannot wrap.
  localparam logic signed [11:0] BX     = 12'(BIRD_X);
  localparam logic signed [11:0] HALF_W = 12'(BIRD_W / 2);
  localparam logic signed [11:0] HALF_H = 12'(BIRD_H / 2);
  localparam logic signed [11:0] PW     = 12'(PIPE_W);
  localparam logic signed [11:0] GH     = 12'(GAP_H);
  localparam logic signed [11:0] LH     = 12'(LAND_H);
  localparam logic signed [11:0] GY_TOP = 12'(V_ACTIVE - 1);

  function automatic logic signed [11:0] abs12(input logic signed [11:0] v);
    return v[11] ? -v : v;
  endfunction

  function automatic logic pipe_cover(input logic signed [11:0] x,
                                      input logic signed [11:0] y,
                                      input logic [9:0] px_u,
                                      input logic [8:0] py_u);
    logic signed [11:0] px;
    logic signed [11:0] py;
    px = signed'({2'b00, px_u});
    py = signed'({3'b000, py_u});
    return (x > px - PW) && (x < px) && !((y > py - GH) && (y < py));
  endfunction

  logic [9:0]            col, row;
  logic                  col_last, row_last, wrap, report;
  logic [8:0]            sh_bird_y;
  logic [10*N_PIPES-1:0] sh_pipe_x;
  logic [9*N_PIPES-1:0]  sh_pipe_y;
  logic [N_PIPES-1:0]    sh_pipe_en;
  logic signed [11:0]    cx, gy, dx, dy;
  logic                  act0, box0, land0, pipe0, hs0, vs0;
  logic                  act1, box1, land1, pipe1, hs1, vs1;
  logic                  bird_vis, set_hit, flag;
  logic [11:0]           pix, rgb_q;
  logic                  hs_q, vs_q, frame_q, collide_q;

  assign col_last = (col == 10'(H_TOTAL - 1));
  assign row_last = (row == 10'(V_TOTAL - 1));
  assign wrap     = col_last && row_last;
  assign report   = (col == 10'd0) && (row == 10'(V_ACTIVE));

  // Pixel and line counters.
  always_ff @(posedge vga_clk or negedge clrn) begin
    if (!clrn) begin
      col <= '0;
      row <= '0;
    end else if (col_last) begin
      col <= '0;
      row <= row_last ? 10'd0 : row + 10'd1;
    end else begin
      col <= col + 10'd1;
    end
  end

  // Latch object positions only at the frame wrap so a frame never tears.
  always_ff @(posedge vga_clk or negedge clrn) begin
    if (!clrn) begin
      sh_bird_y  <= 9'd240;
      sh_pipe_x  <= '0;
      sh_pipe_y  <= '0;
      sh_pipe_en <= '0;
      frame_q    <= 1'b0;
    end else begin
      frame_q <= wrap;
      if (wrap) begin
        sh_bird_y  <= bus.bird_y;
        sh_pipe_x  <= bus.pipe_x;
        sh_pipe_y  <= bus.pipe_y;
        sh_pipe_en <= bus.pipe_en;
      end
    end
  end

  // Stage 0: geometry of the pixel currently being addressed.
  assign cx    = signed'({2'b00, col});
  assign gy    = GY_TOP - signed'({2'b00, row});
  assign dx    = cx - BX;
  assign dy    = gy - signed'({3'b000, sh_bird_y});
  assign act0  = (col < 10'(H_ACTIVE)) && (row < 10'(V_ACTIVE));
  assign box0  = (abs12(dx) <= HALF_W) && (abs12(dy) <= HALF_H);
  assign land0 = (gy < LH);
  assign hs0   = !((col >= 10'(H_ACTIVE + H_FP)) && (col < 10'(H_ACTIVE + H_FP + H_SYNC)));
  assign vs0   = !((row >= 10'(V_ACTIVE + V_FP)) && (row < 10'(V_ACTIVE + V_FP + V_SYNC)));

  // Any enabled pipe covering this pixel.
  always_comb begin
    pipe0 = 1'b0;
    for (int i = 0; i < N_PIPES; i++) begin
      if (sh_pipe_en[i] && pipe_cover(cx, gy, sh_pipe_x[10*i +: 10], sh_pipe_y[9*i +: 9]))
        pipe0 = 1'b1;
    end
  end

  // Stage 1: geometry registered alongside the ROM data for the same pixel.
  always_ff @(posedge vga_clk or negedge clrn) begin
    if (!clrn) begin
      act1  <= 1'b0;
      box1  <= 1'b0;
      land1 <= 1'b0;
      pipe1 <= 1'b0;
      hs1   <= 1'b1;
      vs1   <= 1'b1;
    end else begin
      act1  <= act0;
      box1  <= box0;
      land1 <= land0;
      pipe1 <= pipe0;
      hs1   <= hs0;
      vs1   <= vs0;
    end
  end

  assign bird_vis = box1 && (bus.bird_rgb != KEY_COLOR);
  assign set_hit  = act1 && bird_vis && (land1 || pipe1);

  // Priority layering: bird, land, pipes, background; black outside active.
  always_comb begin
    pix = '0;
    if (act1) begin
      if (bird_vis)   pix = bus.bird_rgb;
      else if (land1) pix = bus.land_rgb;
      else if (pipe1) pix = PIPE_COLOR;
      else            pix = bus.bg_rgb;
    end
  end

  // Stage 2: registered colour and aligned sync.
  always_ff @(posedge vga_clk or negedge clrn) begin
    if (!clrn) begin
      rgb_q <= '0;
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
    end else begin
      rgb_q <= pix;
      hs_q  <= hs1;
      vs_q  <= vs1;
    end
  end

  // Collision accumulates over the visible frame and is published once per frame;
  // a hit on the publish cycle counts toward the next frame.
  always_ff @(posedge vga_clk or negedge clrn) begin
    if (!clrn) begin
      flag      <= 1'b0;
      collide_q <= 1'b0;
    end else begin
      if (report) collide_q <= flag;
      if (set_hit)     flag <= 1'b1;
      else if (report) flag <= 1'b0;
    end
  end

  assign bus.x_addr      = col;
  assign bus.y_addr      = row[8:0];
  assign bus.frame_start = frame_q;
  assign bus.collide     = collide_q;
  assign bus.r           = rgb_q[11:8];
  assign bus.g           = rgb_q[7:4];
  assign bus.b           = rgb_q[3:0];
  assign bus.hs          = hs_q;
  assign bus.vs          = vs_q;

endmodule

// File: tb/tb_pixel_compositor.sv
// Bench for pixel_compositor on a reduced raster (80x56 total, 64x48 visible).
// A reference model pushes expected pixels into a queue when each address is
// issued; they are popped and compared when the output stage presents them.
module tb_pixel_compositor;
  localparam int HA = 64, HFP = 4, HSY = 8, HT = 80;
  localparam int VA = 48, VFP = 2, VSY = 2, VT = 56;
  localparam int NP = 2, PW = 10, GH = 10, LH = 8;
  localparam int BX = 32, BW = 10, BH = 8;

  logic vga_clk;
  logic clrn;
  logic [11:0] bird_color;

  pixel_compositor_if #(.N_PIPES(NP)) bus ();

  pixel_compositor #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_TOTAL(HT),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_TOTAL(VT),
    .N_PIPES(NP), .PIPE_W(PW), .GAP_H(GH), .LAND_H(LH),
    .BIRD_X(BX), .BIRD_W(BW), .BIRD_H(BH),
    .KEY_COLOR(12'hFFF), .PIPE_COLOR(12'h0C0)
  ) dut (
    .vga_clk(vga_clk),
    .clrn(clrn),
    .bus(bus)
  );

  initial vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  function automatic logic [11:0] bg_fn(input logic [9:0] x, input logic [8:0] y);
    return {x[3:0], y[3:0], x[7:4] ^ 4'h9};
  endfunction

  function automatic logic [11:0] land_fn(input logic [9:0] x, input logic [8:0] y);
    return {4'h8, y[3:0] ^ x[3:0], x[5:2]};
  endfunction

  function automatic int abs_i(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Synchronous ROMs: data follows the address by one cycle.
  always @(posedge vga_clk) begin
    bus.bg_rgb   <= bg_fn(bus.x_addr, bus.y_addr);
    bus.land_rgb <= land_fn(bus.x_addr, bus.y_addr);
    bus.bird_rgb <= bird_color;
  end

  int n_tests = 0;
  int n_fail  = 0;

  bit          run_model;
  int          m_col, m_row;
  int          s_bird_y;
  int          s_px [NP];
  int          s_py [NP];
  bit [NP-1:0] s_en;
  bit          m_flag, m_collide, exp_fs;
  logic [13:0] q [$];

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h (model row %0d col %0d)", tag, got, exp, m_row, m_col);
    end
  endtask

  task automatic model_reset();
    m_col = 0; m_row = 0; s_bird_y = 240; s_en = '0;
    for (int i = 0; i < NP; i++) begin s_px[i] = 0; s_py[i] = 0; end
    m_flag = 0; m_collide = 0; exp_fs = 0;
    q.delete();
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_rgb"}, 16'({bus.r, bus.g, bus.b}), 16'h000);
    check({tag, "_hs"}, 16'(bus.hs), 16'd1);
    check({tag, "_vs"}, 16'(bus.vs), 16'd1);
    check({tag, "_fs"}, 16'(bus.frame_start), 16'd0);
    check({tag, "_collide"}, 16'(bus.collide), 16'd0);
    check({tag, "_x"}, 16'(bus.x_addr), 16'd0);
    check({tag, "_y"}, 16'(bus.y_addr), 16'd0);
  endtask

  // One pixel clock: model the issued address at the edge, compare at the falling edge.
  task automatic tick();
    int          gy;
    bit          act, bird, land, pipe;
    logic [11:0] ce;
    logic [13:0] e;
    @(posedge vga_clk);
    if (run_model) begin
      gy   = VA - 1 - m_row;
      act  = (m_col < HA) && (m_row < VA);
      bird = (abs_i(m_col - BX) <= BW / 2) && (abs_i(gy - s_bird_y) <= BH / 2)
             && (bird_color != 12'hFFF);
      land = gy < LH;
      pipe = 0;
      for (int i = 0; i < NP; i++)
        if (s_en[i] && m_col > s_px[i] - PW && m_col < s_px[i]
            && !(gy > s_py[i] - GH && gy < s_py[i])) pipe = 1;
      if (!act)      ce = 12'h000;
      else if (bird) ce = bird_color;
      else if (land) ce = land_fn(10'(m_col), 9'(m_row));
      else if (pipe) ce = 12'h0C0;
      else           ce = bg_fn(10'(m_col), 9'(m_row));
      e = {ce, !(m_col >= HA + HFP && m_col < HA + HFP + HSY),
               !(m_row >= VA + VFP && m_row < VA + VFP + VSY)};
      q.push_back(e);
      if (act && bird && (land || pipe)) m_flag = 1;
      if (m_col == 0 && m_row == VA) begin m_collide = m_flag; m_flag = 0; end
      exp_fs = (m_col == HT - 1) && (m_row == VT - 1);
      if (exp_fs) begin
        s_bird_y = int'(bus.bird_y);
        s_en     = bus.pipe_en;
        for (int i = 0; i < NP; i++) begin
          s_px[i] = int'(bus.pipe_x[10*i +: 10]);
          s_py[i] = int'(bus.pipe_y[9*i +: 9]);
        end
      end
      if (m_col == HT - 1) begin
        m_col = 0;
        m_row = (m_row == VT - 1) ? 0 : m_row + 1;
      end else begin
        m_col++;
      end
    end
    @(negedge vga_clk);
    if (run_model) begin
      check("frame_start", 16'(bus.frame_start), 16'(exp_fs));
      check("collide", 16'(bus.collide), 16'(m_collide));
      if (q.size() >= 2) begin
        e = q.pop_front();
        check("rgb", 16'({bus.r, bus.g, bus.b}), 16'(e[13:2]));
        check("hs", 16'(bus.hs), 16'(e[1]));
        check("vs", 16'(bus.vs), 16'(e[0]));
      end
    end
  endtask

  task automatic run_to(input int r, input int c);
    do tick(); while (!(m_row == r && m_col == c));
  endtask

  initial begin
    run_model   = 0;
    bird_color  = 12'hF80;
    bus.bird_y  = 9'd24;
    bus.pipe_x  = '0;
    bus.pipe_y  = '0;
    bus.pipe_en = '0;
    model_reset();
    clrn = 1'b1;
    #1 clrn = 1'b0;
    repeat (3) @(negedge vga_clk);
    check_reset("reset");
    clrn = 1'b1;
    model_reset();
    run_model = 1;

    // Frame 0: reset shadows (bird off-screen, no pipes).
    run_to(10, 0);
    check("addr_y", 16'(bus.y_addr), 16'd10);
    check("addr_x", 16'(bus.x_addr), 16'd0);

    // Frame 1: bird over background; arm a pipe whose left edge underflows.
    run_to(0, 0);
    run_to(10, 0);
    bus.pipe_x  = {10'd0, 10'd5};
    bus.pipe_y  = {9'd0, 9'd30};
    bus.pipe_en = 2'b01;

    // Frame 2: bird keyed out, mid-frame pipe move must not show until frame 3.
    run_to(0, 0);
    bird_color = 12'hFFF;
    run_to(10, 0);
    bus.pipe_x  = {10'd60, 10'd36};
    bus.pipe_y  = {9'd5, 9'd45};
    bus.pipe_en = 2'b11;
    run_to(30, 0);
    bird_color = 12'hF80;

    // Frame 3: pipe overlaps bird; move it away for frame 4.
    run_to(0, 0);
    run_to(10, 0);
    check("collide_f2", 16'(bus.collide), 16'd0);
    bus.pipe_x = {10'd60, 10'd20};
    run_to(49, 0);
    check("collide_pipe", 16'(bus.collide), 16'd1);

    // Frame 4: clear of pipes; drop the bird into the land for frame 5.
    run_to(0, 0);
    run_to(10, 0);
    bus.bird_y = 9'd6;
    run_to(49, 0);
    check("collide_clear", 16'(bus.collide), 16'd0);

    // Frame 5: bird in land.
    run_to(0, 0);
    run_to(49, 0);
    check("collide_land", 16'(bus.collide), 16'd1);

    // Frame 6: async reset mid-frame while collide is high.
    run_to(0, 0);
    run_to(30, 0);
    check("collide_pre_reset", 16'(bus.collide), 16'd1);
    #2 clrn = 1'b0;
    #1 check_reset("async_reset");
    run_model = 0;
    repeat (2) @(negedge vga_clk);
    check_reset("held_reset");
    clrn = 1'b1;
    model_reset();
    run_model = 1;
    run_to(49, 0);
    check("collide_after_reset", 16'(bus.collide), 16'd0);
    run_to(0, 0);
    run_to(3, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
